// File: rtl/mult_acc_pkg.sv
// Shared types and helpers for the DSP product accumulator.
package mult_acc_pkg;

    // Width of the MULT36X36 DOUT bus.
    localparam int PROD_W = 72;
    // Widest accumulator the extension helper supports.
    localparam int MAX_W = 128;

    // One delay-line stage, tracking a product travelling through the DSP.
    typedef struct packed {
        logic v;
        logic last;
        logic sgn;
    } stage_t;

    // Extend a DSP product to MAX_W bits, then keep only the low 'width' bits.
    function automatic logic [MAX_W-1:0] sext72(
        input logic [PROD_W-1:0] prod,
        input logic              sgn,
        input int                width
    );
        logic [MAX_W-1:0] ext;
        logic [MAX_W-1:0] mask;
        ext  = {{(MAX_W-PROD_W){sgn & prod[PROD_W-1]}}, prod};
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        return ext & mask;
    endfunction

endpackage

// File: rtl/mult_acc_fifo.sv
// First-word fall-through result FIFO over a register array.
// Push and pop in the same cycle are accepted even when full.
module mult_acc_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_pop    = pop & ~empty;
    // A pop frees the slot this push needs, so full does not block it.
    assign do_push   = push & (~full | do_pop);
    assign dout      = mem_reg[rd_ptr_reg];
    assign occupancy = count_reg;

    // Storage write; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mult_acc_drain.sv
// Accumulates pipelined MULT36X36 products into per-group sums and hands
// finished groups out over valid/ready, using issue credits because the DSP
// cannot be stalled.
module mult_acc_drain
    import mult_acc_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int ACC_W   = 80,
    parameter int CNT_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic              issue_last,
    input  logic              signed_mode,
    output logic              can_issue,
    input  logic [PROD_W-1:0] dsp_dout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              proto_err,
    output logic              busy
);

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } result_t;

    stage_t                 line_reg [LATENCY];
    stage_t                 tap;
    logic [LATENCY-1:0]     stage_v;
    logic [LATENCY-1:0]     stage_credit;
    logic                   en_reg;
    logic                   proto_err_reg;
    logic                   group_open_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   ovf_reg;
    logic [ACC_W-1:0]       ext;
    logic [ACC_W-1:0]       base;
    logic [ACC_W-1:0]       acc_next;
    logic [CNT_W-1:0]       cnt_next;
    logic                   ovf_next;
    logic                   cnt_max;
    logic                   sum_ovf;
    logic                   push;
    result_t                push_entry;
    result_t                head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] occupancy;

    assign tap = line_reg[LATENCY-1];

    // Per-stage valid and credit flags; a credit is a last-tagged product in flight.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage_flags
        assign stage_v[gi]      = line_reg[gi].v;
        assign stage_credit[gi] = line_reg[gi].v & line_reg[gi].last;
    end

    // Each last product reserves a FIFO slot from issue until it is popped.
    assign can_issue = en_reg & ~fifo_full
                     & ((int'(occupancy) + $countones(stage_credit)) < DEPTH);

    // Delay line mirroring the DSP pipeline; dropped issues enter as bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) line_reg[i] <= '0;
        end else begin
            line_reg[0] <= '{v: issue & can_issue, last: issue_last, sgn: signed_mode};
            for (int i = 1; i < LATENCY; i++) line_reg[i] <= line_reg[i-1];
        end
    end

    // Sum/count/overflow for the product at the tap this cycle.
    always_comb begin
        ext      = ACC_W'(sext72(dsp_dout, tap.sgn, ACC_W));
        base     = group_open_reg ? acc_reg : '0;
        acc_next = base + ext;
        // Only signed products can overflow; the test follows this product's sign.
        sum_ovf  = tap.sgn & (base[ACC_W-1] == ext[ACC_W-1])
                 & (acc_next[ACC_W-1] != base[ACC_W-1]);
        cnt_max  = &cnt_reg;
        cnt_next = cnt_max ? cnt_reg : cnt_reg + CNT_W'(1);
        ovf_next = (group_open_reg & ovf_reg) | sum_ovf | cnt_max;
    end

    assign push       = tap.v & tap.last;
    assign push_entry = '{data: acc_next, count: cnt_next, ovf: ovf_next};

    // Open-group state: a last tap closes the group, any other valid tap extends it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            group_open_reg <= 1'b0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            ovf_reg        <= 1'b0;
        end else if (tap.v) begin
            if (tap.last) begin
                group_open_reg <= 1'b0;
                acc_reg        <= '0;
                cnt_reg        <= '0;
                ovf_reg        <= 1'b0;
            end else begin
                group_open_reg <= 1'b1;
                acc_reg        <= acc_next;
                cnt_reg        <= cnt_next;
                ovf_reg        <= ovf_next;
            end
        end
    end

    // Issue enable after reset release, and sticky protocol-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_reg        <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            en_reg        <= 1'b1;
            proto_err_reg <= proto_err_reg | (issue & ~can_issue);
        end
    end

    mult_acc_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .din       (push_entry),
        .pop       (res_valid & res_ready),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign res_valid = ~fifo_empty;
    assign res_data  = head.data;
    assign res_count = head.count;
    assign res_ovf   = head.ovf;
    assign proto_err = proto_err_reg;
    assign busy      = (|stage_v) | group_open_reg | (occupancy != '0);

endmodule

// File: tb/tb_mult_acc_drain.sv
// Directed bench for mult_acc_drain with a model of the DSP output pipeline.
module tb_mult_acc_drain;

    localparam int LATENCY = 3;
    localparam int ACC_W   = 80;
    localparam int CNT_W   = 2;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              issue = 1'b0;
    logic              issue_last = 1'b0;
    logic              signed_mode = 1'b0;
    logic              res_ready = 1'b0;
    logic              can_issue;
    logic              res_valid;
    logic              res_ovf;
    logic              proto_err;
    logic              busy;
    logic [71:0]       dsp_dout;
    logic [71:0]       prod_in = '0;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic [71:0]       dsp_pipe [LATENCY];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The DSP itself: product presented with issue appears LATENCY cycles later.
    always_ff @(posedge clk) begin
        dsp_pipe[0] <= prod_in;
        for (int i = 1; i < LATENCY; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
    assign dsp_dout = dsp_pipe[LATENCY-1];

    mult_acc_drain #(
        .LATENCY (LATENCY),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue       (issue),
        .issue_last  (issue_last),
        .signed_mode (signed_mode),
        .can_issue   (can_issue),
        .dsp_dout    (dsp_dout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_count   (res_count),
        .res_ovf     (res_ovf),
        .proto_err   (proto_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, and
    // dsp operand lines carry junk whenever nothing is issued.
    task automatic step();
        @(posedge clk);
        #1;
        prod_in = 72'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue_op(input logic last, input logic sgn, input logic [71:0] p);
        issue       = 1'b1;
        issue_last  = last;
        signed_mode = sgn;
        prod_in     = p;
        step();
        issue       = 1'b0;
        issue_last  = 1'b0;
        signed_mode = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it, then pop it.
    task automatic expect_result(input string tag, input logic [ACC_W-1:0] d,
                                 input logic [CNT_W-1:0] c, input logic o);
        int n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, res_valid, 1'b1);
        check({tag, "_data"},  res_data,  d);
        check({tag, "_count"}, res_count, c);
        check({tag, "_ovf"},   res_ovf,   o);
        $display("result %s data=%0h count=%0d ovf=%0b", tag, res_data, res_count, res_ovf);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_can_issue", can_issue, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_res_data",  res_data,  '0);
        reset = 1'b1;
        check("release_ci_pre", can_issue, 1'b0);
        step();
        check("release_ci", can_issue, 1'b1);

        // Basic group: 6+6+6, result LATENCY+1 cycles after the last issue
        issue_op(1'b0, 1'b0, 72'd6);
        check("basic_busy", busy, 1'b1);
        issue_op(1'b0, 1'b0, 72'd6);
        issue_op(1'b1, 1'b0, 72'd6);
        step();
        step();
        check("basic_not_early", res_valid, 1'b0);
        step();
        check("basic_on_time", res_valid, 1'b1);
        expect_result("basic", 80'd18, 2'd3, 1'b0);
        check("basic_idle_busy", busy, 1'b0);

        // Signed: -2 + 5 = 3; unsigned: (2^72 - 2) + 5 = 2^72 + 3
        issue_op(1'b0, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FFFE);
        issue_op(1'b1, 1'b1, 72'd5);
        expect_result("signed", 80'd3, 2'd2, 1'b0);
        issue_op(1'b0, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FFFE);
        issue_op(1'b1, 1'b0, 72'd5);
        expect_result("unsigned", 80'h0100_0000_0000_0000_0003, 2'd2, 1'b0);

        // Backpressure: four single-product groups exhaust the credits
        check("bp_ci0", can_issue, 1'b1);
        issue_op(1'b1, 1'b0, 72'd1);
        issue_op(1'b1, 1'b0, 72'd2);
        issue_op(1'b1, 1'b0, 72'd3);
        check("bp_ci3", can_issue, 1'b1);
        issue_op(1'b1, 1'b0, 72'd4);
        check("bp_ci4", can_issue, 1'b0);
        idle(6);
        check("bp_ci_full", can_issue, 1'b0);
        check("bp_head", res_data, 80'd1);
        check("bp_perr_before", proto_err, 1'b0);
        issue_op(1'b1, 1'b0, 72'd99);
        check("bp_proto_err", proto_err, 1'b1);
        idle(6);
        res_ready = 1'b1;
        check("bp_ci_no_early", can_issue, 1'b0);
        step();
        res_ready = 1'b0;
        check("bp_ci_after_pop", can_issue, 1'b1);
        $display("result bp1 popped, next head=%0h", res_data);
        check("bp_head2", res_data, 80'd2);
        expect_result("bp2", 80'd2, 2'd1, 1'b0);
        expect_result("bp3", 80'd3, 2'd1, 1'b0);
        expect_result("bp4", 80'd4, 2'd1, 1'b0);
        check("bp_drained", res_valid, 1'b0);
        check("bp_ci_back", can_issue, 1'b1);

        // Simultaneous push and pop at occupancy 3
        issue_op(1'b1, 1'b0, 72'd10);
        issue_op(1'b1, 1'b0, 72'd11);
        issue_op(1'b1, 1'b0, 72'd12);
        idle(5);
        issue_op(1'b1, 1'b0, 72'd13);
        step();
        step();
        check("pp_head", res_data, 80'd10);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("pp_ci", can_issue, 1'b1);
        expect_result("pp11", 80'd11, 2'd1, 1'b0);
        expect_result("pp12", 80'd12, 2'd1, 1'b0);
        expect_result("pp13", 80'd13, 2'd1, 1'b0);
        check("pp_drained", res_valid, 1'b0);

        // Count saturation: five products with a 2-bit counter
        for (int i = 0; i < 4; i++) issue_op(1'b0, 1'b0, 72'd1);
        issue_op(1'b1, 1'b0, 72'd1);
        expect_result("sat", 80'd5, 2'd3, 1'b1);

        // Reset in the middle of a group
        issue_op(1'b0, 1'b0, 72'd7);
        reset = 1'b0;
        step();
        check("mid_rst_ci", can_issue, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        step();
        reset = 1'b1;
        idle(8);
        check("post_rst_valid", res_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_perr", proto_err, 1'b0);
        issue_op(1'b1, 1'b0, 72'd9);
        expect_result("fresh", 80'd9, 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
